// File: rtl/grid_error_loader.sv
// grid_error_loader
//   Fills the 8x8 grid-region error window scanned by the stroke-placement
//   max-search. Accepts 64 raster-ordered (reference, canvas) RGB pixel pairs,
//   computes a per-pixel colour error for each pair, buffers all 64 errors and
//   presents the window, its area error sum and a stroke-needed flag through a
//   valid/ready handshake.
//
//   Optional feature macro: GRID_ERR_SQUARE_EN
//     undefined : error = |dR| + |dG| + |dB|        (0..765)
//     defined   : error = dR^2 + dG^2 + dB^2        (0..195075)
//
// Ports
//   i_clk           clock, rising edge
//   i_rst           synchronous active-high reset
//   i_start         begin loading a new window (honoured only in IDLE)
//   i_valid         pixel pair valid
//   o_ready         pixel pair accepted this cycle when i_valid is high
//   i_ref_rgb       reference pixel {R,G,B}
//   i_canvas_rgb    canvas pixel {R,G,B}
//   o_busy          block is not idle
//   o_region_valid  window complete and stable
//   i_region_ready  downstream consumes the window
//   o_region        element [r][c] at bits (r*8+c)*ERR_W +: ERR_W
//   o_area_err      sum of all 64 elements
//   o_need_stroke   (o_area_err >> 6) > THRESH
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for i_start; window contents retained
// LOAD  | accepting pixel pairs, one element per accept
// HOLD  | window complete, o_region_valid high until consumed

module grid_error_loader #(
  parameter int GRID   = 8,
  parameter int ERR_W  = 24,
  parameter int THRESH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [23:0]                i_ref_rgb,
  input  logic [23:0]                i_canvas_rgb,
  output logic                       o_busy,
  output logic                       o_region_valid,
  input  logic                       i_region_ready,
  output logic [GRID*GRID*ERR_W-1:0] o_region,
  output logic [ERR_W-1:0]           o_area_err,
  output logic                       o_need_stroke
);

  localparam int N = GRID * GRID;

`ifdef GRID_ERR_SQUARE_EN
  localparam int PIX_W = 18;
`else
  localparam int PIX_W = 10;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [5:0]       index_q;
  logic [ERR_W-1:0] acc_q;
  logic [ERR_W-1:0] acc_next;
  logic             need_q;
  logic [ERR_W-1:0] window_q [N];

  logic             accept;
  logic [7:0]       d_r, d_g, d_b;
  logic [PIX_W-1:0] pix_err;
  logic [ERR_W-1:0] pix_err_ext;

  function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // per-pixel error
  always_comb begin
    d_r = abs_diff(i_ref_rgb[23:16], i_canvas_rgb[23:16]);
    d_g = abs_diff(i_ref_rgb[15:8],  i_canvas_rgb[15:8]);
    d_b = abs_diff(i_ref_rgb[7:0],   i_canvas_rgb[7:0]);
`ifdef GRID_ERR_SQUARE_EN
    pix_err = PIX_W'({8'd0, d_r} * {8'd0, d_r})
            + PIX_W'({8'd0, d_g} * {8'd0, d_g})
            + PIX_W'({8'd0, d_b} * {8'd0, d_b});
`else
    pix_err = PIX_W'(d_r) + PIX_W'(d_g) + PIX_W'(d_b);
`endif
    pix_err_ext = ERR_W'(pix_err);
  end

  assign accept   = (state_q == ST_LOAD) && i_valid;
  assign acc_next = acc_q + pix_err_ext;

  // next state / outputs
  always_comb begin
    state_d = state_q;
    o_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        o_ready = 1'b1;
        if (i_valid && (index_q == 6'd63)) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        // i_start is deliberately not looked at here, so a start coinciding
        // with the handshake still lands in IDLE.
        if (i_region_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      index_q <= '0;
      acc_q   <= '0;
      need_q  <= 1'b0;
      for (int i = 0; i < N; i++) window_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_IDLE) && i_start) begin
        index_q <= '0;
        acc_q   <= '0;
        need_q  <= 1'b0;
      end
      if (accept) begin
        window_q[index_q] <= pix_err_ext;
        acc_q             <= acc_next;
        index_q           <= index_q + 6'd1;
        // tracked on every accept so it is already settled on entry to HOLD
        need_q            <= (acc_next >> 6) > ERR_W'(THRESH);
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_region
    assign o_region[g*ERR_W +: ERR_W] = window_q[g];
  end

  assign o_busy         = (state_q != ST_IDLE);
  assign o_region_valid = (state_q == ST_HOLD);
  assign o_area_err     = acc_q;
  assign o_need_stroke  = need_q;

endmodule

// File: tb/tb_grid_error_loader.sv
// tb_grid_error_loader
//   Directed self-checking bench for grid_error_loader. Expected values are
//   hand-computed constants, selected per error metric by GRID_ERR_SQUARE_EN.

module tb_grid_error_loader;

  localparam int ERR_W = 24;

`ifdef GRID_ERR_SQUARE_EN
  localparam int E_UNI   = 30;       // 1+4+25
  localparam int E_MAX   = 195075;
  localparam int E_BP    = 75;       // 3*25
  localparam int E_16    = 256;
  localparam int E_17    = 289;
  localparam bit N_UNI   = 1;
  localparam bit N_HOT   = 1;
  localparam bit N_BP    = 1;
  localparam bit N_16    = 1;
`else
  localparam int E_UNI   = 8;        // 1+2+5
  localparam int E_MAX   = 765;
  localparam int E_BP    = 15;
  localparam int E_16    = 16;
  localparam int E_17    = 17;
  localparam bit N_UNI   = 0;
  localparam bit N_HOT   = 0;
  localparam bit N_BP    = 0;
  localparam bit N_16    = 0;
`endif

  logic                  clk;
  logic                  i_rst;
  logic                  i_start;
  logic                  i_valid;
  logic                  o_ready;
  logic [23:0]           i_ref_rgb;
  logic [23:0]           i_canvas_rgb;
  logic                  o_busy;
  logic                  o_region_valid;
  logic                  i_region_ready;
  logic [64*ERR_W-1:0]   o_region;
  logic [ERR_W-1:0]      o_area_err;
  logic                  o_need_stroke;

  int n_chk = 0;
  int n_err = 0;

  grid_error_loader dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_start        (i_start),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_ref_rgb      (i_ref_rgb),
    .i_canvas_rgb   (i_canvas_rgb),
    .o_busy         (o_busy),
    .o_region_valid (o_region_valid),
    .i_region_ready (i_region_ready),
    .o_region       (o_region),
    .o_area_err     (o_area_err),
    .o_need_stroke  (o_need_stroke)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic release_window();
    @(negedge clk);
    i_region_ready = 1'b1;
    @(negedge clk);
    i_region_ready = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_ready"},  32'(o_ready), 0);
    check({tag, "_valid"},  32'(o_region_valid), 0);
    check({tag, "_busy"},   32'(o_busy), 0);
    check({tag, "_area"},   32'(o_area_err), 0);
    check({tag, "_need"},   32'(o_need_stroke), 0);
  endtask

  task automatic check_window(input string tag, input int def_val, input int hot_idx,
                              input int hot_val);
    for (int i = 0; i < 64; i++) begin
      check($sformatf("%s_elem%0d", tag, i), 32'(o_region[i*ERR_W +: ERR_W]),
            (i == hot_idx) ? 32'(hot_val) : 32'(def_val));
    end
  endtask

  // Drives pixel pairs at negedges; an accept happens at the following posedge
  // whenever i_valid and o_ready are both high. lat = cycles from the first
  // accept to the first cycle o_region_valid is seen (full windows only).
  task automatic load_window(input logic [23:0] ref_px, input logic [23:0] can_px,
                             input int hot_idx, input logic [23:0] hot_ref,
                             input logic [23:0] hot_can, input bit gaps,
                             input int n_acc, output int lat);
    int n, cyc, first;
    n = 0; cyc = 0; first = -1; lat = -1;
    while (n < n_acc && cyc < 2000) begin
      @(negedge clk);
      i_valid      = !(gaps && (cyc % 2 == 1));
      i_ref_rgb    = (n == hot_idx) ? hot_ref : ref_px;
      i_canvas_rgb = (n == hot_idx) ? hot_can : can_px;
      if (i_valid && o_ready) begin
        if (first < 0) first = cyc;
        n++;
      end
      cyc++;
    end
    if (n < n_acc) check("load_timeout", 32'(n), 32'(n_acc));
    if (n_acc == 64) begin
      while (cyc < 3000) begin
        @(negedge clk);
        i_valid = 1'b0;
        if (o_region_valid) break;
        cyc++;
      end
      check("region_valid_seen", 32'(o_region_valid), 1);
      lat = cyc - first;
    end else begin
      @(negedge clk);
      i_valid = 1'b0;
    end
  endtask

  int lat;

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_valid = 1'b0; i_region_ready = 1'b0;
    i_ref_rgb = '0; i_canvas_rgb = '0;
    @(negedge clk);
    @(negedge clk);
    i_rst = 1'b0;
    @(negedge clk);
    check_idle_zero("reset");
    check_window("reset", 0, -1, 0);

    // Uniform window
    pulse_start();
    check("load_busy", 32'(o_busy), 1);
    check("load_ready", 32'(o_ready), 1);
    load_window(24'h102030, 24'h0F2235, -1, 24'h0, 24'h0, 1'b0, 64, lat);
    check("uni_latency", 32'(lat), 64);
    check("uni_ready_hold", 32'(o_ready), 0);
    check("uni_area", 32'(o_area_err), 32'(E_UNI * 64));
    check("uni_need", 32'(o_need_stroke), 32'(N_UNI));
    check_window("uni", E_UNI, -1, 0);
    release_window();
    check("uni_rel_valid", 32'(o_region_valid), 0);

    // Hot pixel at index 19 -> element [2][3]
    pulse_start();
    load_window(24'h123456, 24'h123456, 19, 24'hFFFFFF, 24'h000000, 1'b0, 64, lat);
    check("hot_area", 32'(o_area_err), 32'(E_MAX));
    check("hot_need", 32'(o_need_stroke), 32'(N_HOT));
    check_window("hot", 0, 19, E_MAX);
    release_window();

    // Backpressure: gaps on input, held window with ignored starts
    pulse_start();
    load_window(24'h000000, 24'h050505, -1, 24'h0, 24'h0, 1'b1, 64, lat);
    check_window("bp", E_BP, -1, 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      i_start = (k % 2 == 0);
      i_region_ready = 1'b0;
      check("bp_hold_valid", 32'(o_region_valid), 1);
      check("bp_hold_area", 32'(o_area_err), 32'(E_BP * 64));
      check("bp_hold_need", 32'(o_need_stroke), 32'(N_BP));
      check("bp_hold_ready", 32'(o_ready), 0);
      check("bp_hold_busy", 32'(o_busy), 1);
      check("bp_hold_elem63", 32'(o_region[63*ERR_W +: ERR_W]), 32'(E_BP));
    end
    // start coincident with handshake completion is ignored
    @(negedge clk);
    i_start = 1'b1;
    i_region_ready = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_region_ready = 1'b0;
    check("bp_rel_valid", 32'(o_region_valid), 0);
    check("bp_rel_busy", 32'(o_busy), 0);
    check("bp_rel_ready", 32'(o_ready), 0);
    check("bp_retain_elem0", 32'(o_region[0 +: ERR_W]), 32'(E_BP));
    @(negedge clk);
    check("bp_still_idle", 32'(o_busy), 0);

    // Reset mid-load
    pulse_start();
    load_window(24'hFFFFFF, 24'h000000, -1, 24'h0, 24'h0, 1'b0, 30, lat);
    check("mid_busy", 32'(o_busy), 1);
    check("mid_area_partial", 32'(o_area_err), 32'(E_MAX * 30));
    do_reset();
    check_idle_zero("midrst");
    check_window("midrst", 0, -1, 0);
    pulse_start();
    load_window(24'h102030, 24'h0F2235, -1, 24'h0, 24'h0, 1'b0, 64, lat);
    check("midrst_latency", 32'(lat), 64);
    check("midrst_area", 32'(o_area_err), 32'(E_UNI * 64));
    check_window("midrst_win", E_UNI, -1, 0);
    release_window();

    // Threshold boundary
    pulse_start();
    load_window(24'h000000, 24'h100000, -1, 24'h0, 24'h0, 1'b0, 64, lat);
    check("th16_area", 32'(o_area_err), 32'(E_16 * 64));
    check("th16_need", 32'(o_need_stroke), 32'(N_16));
    release_window();
    pulse_start();
    load_window(24'h000000, 24'h110000, -1, 24'h0, 24'h0, 1'b0, 64, lat);
    check("th17_area", 32'(o_area_err), 32'(E_17 * 64));
    check("th17_need", 32'(o_need_stroke), 1);
    release_window();

    // Maximum error on every pixel
    pulse_start();
    load_window(24'hFFFFFF, 24'h000000, -1, 24'h0, 24'h0, 1'b0, 64, lat);
    check("max_area", 32'(o_area_err), 32'(E_MAX * 64));
    check("max_need", 32'(o_need_stroke), 1);
    check_window("max", E_MAX, -1, 0);
    release_window();
    check("final_busy", 32'(o_busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/grid_error_loader.md
Name: grid_error_loader

Overview:
- Stage directly upstream of the stroke-placement max-search; fills the 8x8 grid-region error window that stage scans for its maximum.
- Accepts a raster-ordered stream of 64 (reference, canvas) RGB pixel pairs and computes a per-pixel colour error for each pair.
- Buffers the 64 errors and presents the full window plus area error sum and stroke-needed flag via valid/ready handshake.

Parameters:
- GRID, 8, window side; fixed at 8 (64 elements, 6-bit index).
- ERR_W, 24, width of each window element and of area sum.
- THRESH, 16, stroke threshold compared against mean area error.

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_start  in  1  begin loading a new window (honoured only in IDLE).
- i_valid  in  1  pixel pair valid.
- o_ready  out  1  block accepts a pixel pair this cycle.
- i_ref_rgb  in  24  reference pixel {R[23:16],G[15:8],B[7:0]}.
- i_canvas_rgb  in  24  canvas pixel, same packing.
- o_busy  out  1  state != IDLE.
- o_region_valid  out  1  window complete and stable.
- i_region_ready  in  1  downstream consumes window.
- o_region  out  GRID*GRID*ERR_W  element [r][c] at bits (r*8+c)*24 +: 24.
- o_area_err  out  ERR_W  sum of all 64 elements.
- o_need_stroke  out  1  (o_area_err >> 6) > THRESH.

Behaviour:
- Reset (i_rst=1 at edge): state IDLE, index 0, accumulator 0, all window elements 0, o_ready 0, o_region_valid 0, o_busy 0, o_area_err 0, o_need_stroke 0. Applies from any state, including mid-LOAD/HOLD; partial window discarded.
- Per-pixel error: |dR|+|dG|+|dB|, each channel 8-bit unsigned absolute difference; range 0..765, zero-extended to ERR_W. Area sum max 48960, no overflow.
- FSM IDLE: o_ready=0. i_start=1 -> LOAD; index and accumulator cleared on that edge.
- FSM LOAD: o_ready=1. Accept = i_valid&&o_ready. On accept: element[index>>3][index&7] and accumulator updated on the same edge; index increments. Accept with index=63 -> HOLD; o_region_valid=1 the next cycle. No accept cycles stall without side effects.
- FSM HOLD: o_ready=0, o_region_valid=1; o_region, o_area_err and o_need_stroke stable. i_region_ready=1 -> IDLE next cycle; o_region_valid drops; window contents retained, not cleared.
- i_start ignored in LOAD and HOLD. i_start and handshake completion in the same cycle: i_start ignored, return to IDLE.
- o_area_err and o_need_stroke registered, valid whenever o_region_valid=1. Comparison is strict greater-than on the truncated mean.
- Min latency: first accept to o_region_valid = 64 cycles.

Optional Feature:
- Macro GRID_ERR_SQUARE_EN.
- Defined: per-pixel error = dR^2+dG^2+dB^2, range 0..195075 (18 bits); area sum max 12484800, fits 24 bits.
- Undefined: Manhattan error as above. Handshake, timing and threshold rule identical in both cases.

Test Plan:
- Uniform window: reset, start, 64 pairs ref=0x102030 canvas=0x0F2235, i_valid constant -> all elements 8, o_area_err 512, o_need_stroke 0, o_region_valid at cycle 64 after first accept.
- Hot pixel: index 19 ref=0xFFFFFF canvas=0x000000, others equal -> element[2][3]=765, rest 0, area 765, need 0.
- Backpressure: i_valid gaps every other cycle; hold i_region_ready=0 for 10 cycles with i_start pulses -> outputs stable, start ignored. Then i_region_ready=1 -> IDLE next cycle, o_busy 0.
- Reset mid-load: i_rst after 30 accepts -> all outputs 0. New start needs full 64 accepts; the earlier 30 pixels do not contribute.
- Threshold boundary: all errors 16 -> area 1024, need 0. All errors 17 -> area 1088, need 1.
- GRID_ERR_SQUARE_EN: all pairs ref=0xFFFFFF canvas=0x000000 -> elements 195075, area 12484800, need 1.
